vga_timing_gen: RTL



---
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between vga_timing_gen (master) and the draw/game-logic consumers (slave).
interface vga_timing_gen_if #(
   parameter int unsigned CNT_W       = 11,
   parameter int unsigned FRAME_CNT_W = 8
);
   logic                   en;
   logic                   pix_ce;
   logic [CNT_W-1:0]       hcount;
   logic [CNT_W-1:0]       vcount;
   logic                   hsync;
   logic                   hblnk;
   logic                   vsync;
   logic                   vblnk;
   logic                   line_tick;
   logic                   frame_tick;
   logic                   timing_tick;
   logic [FRAME_CNT_W-1:0] frame_cnt;

   modport master (
      input  en,
      output pix_ce, hcount, vcount, hsync, hblnk, vsync, vblnk,
             line_tick, frame_tick, timing_tick, frame_cnt
   );

   modport slave (
      output en,
      input  pix_ce, hcount, vcount, hsync, hblnk, vsync, vblnk,
             line_tick, frame_tick, timing_tick, frame_cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counters, sync/blank, pixel clock enable and tick pulses.
// Define VGA_TIMING_FRAME_CNT_EN to build the frame counter; otherwise frame_cnt is constant 0.
module vga_timing_gen #(
   parameter int unsigned CNT_W       = 11,
   parameter int unsigned H_ACTIVE    = 800,
   parameter int unsigned H_FP        = 40,
   parameter int unsigned H_SYNC      = 128,
   parameter int unsigned H_BP        = 88,
   parameter int unsigned V_ACTIVE    = 600,
   parameter int unsigned V_FP        = 1,
   parameter int unsigned V_SYNC      = 4,
   parameter int unsigned V_BP        = 23,
   parameter bit          HSYNC_POL   = 1'b1,
   parameter bit          VSYNC_POL   = 1'b1,
   parameter int unsigned PIX_DIV     = 1,
   parameter int unsigned FRAME_CNT_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   vga_timing_gen_if.master vif
);
   localparam int unsigned HTOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned HSYNCSTART = H_ACTIVE + H_FP;
   localparam int unsigned VTOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned VSYNCSTART = V_ACTIVE + V_FP;
   localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

   if (HTOTAL > CNT_SPAN) begin : g_bad_htotal
      $error("vga_timing_gen: HTOTAL does not fit in CNT_W bits");
   end
   if (VTOTAL > CNT_SPAN) begin : g_bad_vtotal
      $error("vga_timing_gen: VTOTAL does not fit in CNT_W bits");
   end
   if (PIX_DIV == 0 || PIX_DIV > 16) begin : g_bad_div
      $error("vga_timing_gen: PIX_DIV must be in 1..16");
   end

   localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS    = CNT_W'(HSYNCSTART);
   localparam logic [CNT_W-1:0] H_SE    = CNT_W'(HSYNCSTART + H_SYNC - 1);
   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HTOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SS    = CNT_W'(VSYNCSTART);
   localparam logic [CNT_W-1:0] V_SE    = CNT_W'(VSYNCSTART + V_SYNC - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VTOTAL - 1);

   logic             pix_ce;
   logic [CNT_W-1:0] hcount, vcount;
   logic [CNT_W-1:0] h_nxt, v_nxt;
   logic             h_wrap;
   logic             hsync, hblnk, vsync, vblnk;
   logic             line_tick, frame_tick, timing_tick;

   if (PIX_DIV == 1) begin : g_nodiv
      assign pix_ce = vif.en;
   end else begin : g_div
      localparam int unsigned       PS_W    = $clog2(PIX_DIV);
      localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PIX_DIV - 1);
      logic [PS_W-1:0] presc;

      always_ff @(posedge clk) begin
         if (rst)
            presc <= '0;
         else if (vif.en)
            presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);
      end

      assign pix_ce = vif.en & (presc == PS_LAST);
   end

   always_comb begin
      h_wrap = (hcount == H_LAST);
      h_nxt  = h_wrap ? '0 : hcount + CNT_W'(1);
      v_nxt  = vcount;
      if (h_wrap)
         v_nxt = (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
   end

   // Decodes are taken from the next counter values so each registered output
   // lines up with the hcount/vcount it is presented alongside.
   always_ff @(posedge clk) begin
      if (rst) begin
         hcount <= '0;
         vcount <= '0;
         hblnk  <= 1'b0;
         vblnk  <= 1'b0;
         hsync  <= ~HSYNC_POL;
         vsync  <= ~VSYNC_POL;
      end else if (pix_ce) begin
         hcount <= h_nxt;
         vcount <= v_nxt;
         hblnk  <= (h_nxt >= H_ACT_C);
         vblnk  <= (v_nxt >= V_ACT_C);
         hsync  <= (h_nxt >= H_SS && h_nxt <= H_SE) ? HSYNC_POL : ~HSYNC_POL;
         vsync  <= (v_nxt >= V_SS && v_nxt <= V_SE) ? VSYNC_POL : ~VSYNC_POL;
      end
   end

   assign line_tick   = pix_ce & h_wrap;
   assign frame_tick  = line_tick & (vcount == V_LAST);
   assign timing_tick = pix_ce & (hcount == '0) & (vcount == V_SS);

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [FRAME_CNT_W-1:0] frame_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         frame_cnt <= '0;
      else if (frame_tick)
         frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
   end

   assign vif.frame_cnt = frame_cnt;
`else
   assign vif.frame_cnt = '0;
`endif

   assign vif.pix_ce      = pix_ce;
   assign vif.hcount      = hcount;
   assign vif.vcount      = vcount;
   assign vif.hsync       = hsync;
   assign vif.hblnk       = hblnk;
   assign vif.vsync       = vsync;
   assign vif.vblnk       = vblnk;
   assign vif.line_tick   = line_tick;
   assign vif.frame_tick  = frame_tick;
   assign vif.timing_tick = timing_tick;
endmodule
